// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arbiter_pkg;

  localparam int ARB_PORT_CPU = 0;
  localparam int ARB_PORT_DMA = 1;

  // Word access; also the funct3 driven onto the memory when nobody is granted.
  localparam logic [2:0] FUNCT3_LW = 3'b010;

  // Round-robin pointer: which port wins when both request.
  typedef enum logic {
    RR_CPU = 1'b0,
    RR_DMA = 1'b1
  } rr_t;

  // One slot of the read-latency pipe.
  typedef struct packed {
    logic valid;
    logic owner;
  } arb_rsp_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with one-hot (or zero) grant.
// Latency: grant is combinational from req; pointer updates at the edge ending a grant.
// Backpressure: grant is forced to zero while rst is high.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_t rr_q;
  rr_t rr_d;

  // Pointer register; reset favours the CPU port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= RR_CPU;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Grant selection and pointer advance: after any grant the other port is favoured.
  always_comb begin
    gnt  = 2'b00;
    rr_d = rr_q;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (rr_q == RR_CPU) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
      if (gnt[ARB_PORT_CPU]) begin
        rr_d = RR_DMA;
      end else if (gnt[ARB_PORT_DMA]) begin
        rr_d = RR_CPU;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between CPU (port 0) and DMA (port 1), round-robin.
// Latency: grant and memory drive combinational; read data returns RD_LAT cycles after grant.
// Backpressure: req_ready per port; responses cannot be stalled and must always be accepted.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  input  logic [1:0][2:0]        req_funct3,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   mem_wen,
  output logic [ADDR_W-1:0]      mem_ra,
  output logic [ADDR_W-1:0]      mem_wa,
  output logic [DATA_W-1:0]      mem_wd,
  output logic [2:0]             mem_funct3,
  input  logic [DATA_W-1:0]      mem_rd
);

  logic [1:0] gnt;
  logic       any_gnt;
  logic       win;
  logic       rd_push;
  arb_rsp_t   pipe_q [RD_LAT];
  arb_rsp_t   rsp_due;

  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign any_gnt   = |gnt;
  assign win       = gnt[ARB_PORT_DMA];
  assign rd_push   = any_gnt & ~req_we[win];
  assign rsp_due   = pipe_q[RD_LAT-1];

  // Steer the winner onto the memory; idle drives a quiet word access at address 0.
  always_comb begin
    mem_wen    = 1'b0;
    mem_ra     = '0;
    mem_wa     = '0;
    mem_wd     = '0;
    mem_funct3 = FUNCT3_LW;
    if (any_gnt) begin
      mem_wen    = req_we[win];
      mem_ra     = req_addr[win];
      mem_wa     = req_addr[win];
      mem_wd     = req_wdata[win];
      mem_funct3 = req_funct3[win];
    end
  end

  // Read-latency shift pipe; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_q[0].valid <= rd_push;
      pipe_q[0].owner <= win;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  // Route the memory read data to the port that issued the read.
  always_comb begin
    rsp_valid = 2'b00;
    rsp_rdata = '0;
    if (rsp_due.valid && !rst) begin
      rsp_valid[rsp_due.owner] = 1'b1;
      rsp_rdata                = mem_rd;
    end
  end

`ifndef SYNTHESIS
  logic [3:0] rd_outstanding;

  // Reads granted but not yet answered, so a response can be tied to a real grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_outstanding <= '0;
    end else begin
      rd_outstanding <= rd_outstanding + 4'(rd_push) - 4'(|rsp_valid);
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_req_chk
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      req_valid[p] && !req_ready[p] |=> req_valid[p] && $stable(req_we[p]) &&
      $stable(req_addr[p]) && $stable(req_wdata[p]) && $stable(req_funct3[p]));
  end

  a_rsp_owned: assert property (@(posedge clk) disable iff (rst)
    (|rsp_valid) |-> (rd_outstanding != 4'd0));

  a_rsp_onehot: assert property (@(posedge clk) $onehot0(rsp_valid));
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port unified memory between two requesters: port 0 = CPU core, port 1 = DMA/program loader. Each request uses a valid/ready handshake, and arbitration is round-robin. Read responses are pipelined with a fixed memory read latency RD_LAT, and each response is routed back to the port that issued it. The block sits between the core's memory interface and the memory macro. One grant per cycle, unlimited outstanding reads within the latency pipe.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RD_LAT, 1, cycles from address sampled at posedge to mem_rd valid; legal 1..4

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  2  per-port request valid, bit i = port i
req_ready  out  2  per-port grant; handshake completes when valid&ready
req_we  in  2  per-port write flag (1 = store, 0 = load)
req_addr  in  2xADDR_W  per-port byte address
req_wdata  in  2xDATA_W  per-port store data
req_funct3  in  2x3  per-port RV32 load/store funct3
rsp_valid  out  2  per-port read-data valid, one-cycle pulse
rsp_rdata  out  DATA_W  read data, shared by both ports, qualified by rsp_valid
mem_wen  out  1  memory write enable
mem_ra  out  ADDR_W  memory read address
mem_wa  out  ADDR_W  memory write address
mem_wd  out  DATA_W  memory write data
mem_funct3  out  3  memory access width/sign
mem_rd  in  DATA_W  memory read data

Behaviour:
- Reset:
  - Asynchronous: all state clears immediately on rst, not at the next edge.
  - rr pointer favours port 0.
  - Latency pipe is emptied; in-flight reads are dropped and no rsp_valid is issued for them.
  - Outputs during rst: req_ready=0, rsp_valid=0, mem_wen=0.
- Arbitration (combinational in cycle T):
  - Only one valid: that port wins.
  - Both valid: the port pointed to by rr wins.
  - req_ready is one-hot or zero, and is never asserted to a port whose valid is low.
- rr pointer update:
  - At the posedge ending T, when a grant occurred, rr <= the other port.
  - No grant: rr holds.
  - Result under contention: strict alternation 0,1,0,1...
- Memory drive in T:
  - mem_ra = mem_wa = winner addr.
  - mem_wd = winner wdata.
  - mem_funct3 = winner funct3.
  - mem_wen = winner we.
  - No grant: addresses and wd = 0, funct3 = 3'b010, wen = 0.
- Writes:
  - Complete in the grant cycle; no response is generated.
- Reads:
  - A read granted in T pushes {valid=1, owner} into a RD_LAT-deep shift pipe.
  - At T+RD_LAT, rsp_valid[owner]=1 and rsp_rdata=mem_rd.
  - Responses return in issue order; at most one rsp_valid bit is high per cycle.
  - rsp_rdata is 0 when no response is due.
- Back-to-back:
  - A new grant is allowed every cycle, including cycles in which a response is being delivered.
  - There is no response backpressure; requesters must always accept rsp_valid.
- Hazards:
  - A write at T followed by a read of the same address at T+1 must return the new data; the memory provides write-before-read across edges.
  - Write and read in the same cycle is impossible (single grant).
- Requester rules (checked by assertions):
  - Once valid is high, it stays high with stable we/addr/wdata/funct3 until ready.
  - rsp_valid must never be asserted without a matching earlier read grant.
- Reset mid-operation:
  - rst asserted while reads are in flight: no rsp_valid follows, even after deassert.
  - The first grant after reset goes to port 0 if both ports are valid.

Decomposition:
- Shared types package additions:
  - ARB_PORT_CPU=0 and ARB_PORT_DMA=1 constants.
  - FUNCT3_LW=3'b010 idle/fetch constant.
  - arb_rsp_t struct {valid, owner}.
- Sub-module rr_arbiter2: 2-way round-robin arbiter, containing the rr flop and the one-hot grant logic.
- Latency pipe and mux remain in mem_arbiter.

Test Plan:
- Port 0 only reads addr 0x100 (mem holds 0xDEADBEEF), RD_LAT=1 -> req_ready[0]=1 in T; rsp_valid[0]=1 and rsp_rdata=0xDEADBEEF in T+1; rsp_valid[1] stays 0.
- Both ports continuously valid, reading 0x0/0x4 -> grants alternate 0,1,0,1 starting with port 0 after reset; responses alternate owners, each RD_LAT after its grant.
- RD_LAT=3, port 1 issues 4 consecutive reads 0x10..0x1C -> 4 consecutive rsp_valid[1] pulses at T+3..T+6, data in order.
- Port 0 writes 0xCAFEF00D to 0x200 (funct3=010), then port 1 reads 0x200 next cycle -> mem_wen=1 only in the write cycle; port 1 receives 0xCAFEF00D.
- Port 1 issues a byte store (funct3=000) -> mem_funct3=000, mem_wa=port-1 addr, no rsp_valid generated.
- Reads in flight with RD_LAT=2, assert rst for 1 cycle -> no rsp_valid ever follows; post-reset simultaneous requests are granted to port 0 first.
